// File: rtl/requant_pkg.sv
// -----------------------------------------------------------------------------
// requant_pkg
// Shared constants and helpers for the requantisation pipeline.
//   D_W_GROW  : bits added to ACC_WIDTH for d = acc - Z_WEIGHTS*ai
//               (32-bit zero-point times ACC_WIDTH activation, plus one carry bit)
//   P_W_GROW  : bits added to the stage-1 width for p = d * M_MUL
//               (multiplier is treated as a 33-bit non-negative signed value)
//   SAT_CNT_W : width of the saturation event counter
//   CLAMP_W   : common width used by the clamp helpers; each lane's widest
//               intermediate (ACC_WIDTH + 66 bits) must fit, so ACC_WIDTH <= 62
// -----------------------------------------------------------------------------
package requant_pkg;

    localparam int D_W_GROW  = 33;
    localparam int P_W_GROW  = 33;
    localparam int SAT_CNT_W = 16;
    localparam int CLAMP_W   = 128;

    // Clamp v into [lo, hi]; callers sign-extend to CLAMP_W and narrow the result.
    function automatic logic signed [CLAMP_W-1:0] clamp_val(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        logic signed [CLAMP_W-1:0] res;
        res = v;
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end
        return res;
    endfunction

    // True when clamp_val would alter v.
    function automatic logic clamp_hit(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/requant_lane.sv
// -----------------------------------------------------------------------------
// requant_lane
// One lane of the requantisation datapath, three register stages:
//   S1: d = acc - Z_WEIGHTS*ai             (bias carried alongside)
//   S2: p = d * M_MUL                      (M_MUL non-negative)
//   S3: v = round_half_up(p / 2^SHIFT) + bias + Z_OUT, clamped to the
//       output range (out_o / sat_o) and to the ACC_WIDTH range (long_out_o)
// Ports:
//   clk, rst     clock, synchronous active-high reset (output register only)
//   en_i         advance S1/S2
//   out_ld_i     load the output register (advance with a real beat in S2)
//   ai_i         shared activation-sum term
//   acc_i        lane accumulator
//   bias_i       lane bias in output scale
//   out_o        saturated quantised output
//   long_out_o   result clamped to ACC_WIDTH
//   sat_o        out_o was clamped for the held beat
//   sat_d_o      clamp indication for the beat currently in S2 (next sat_o)
// -----------------------------------------------------------------------------
module requant_lane
    import requant_pkg::*;
#(
    parameter int          ACC_WIDTH = 32,
    parameter int          OUT_WIDTH = 8,
    parameter int          Z_WEIGHTS = 5,
    parameter logic [31:0] M_MUL     = 32'd2094967296,
    parameter int          SHIFT     = 32,
    parameter int          Z_OUT     = 0,
    parameter int          RELU_EN   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic                        out_ld_i,
    input  logic signed [ACC_WIDTH-1:0] ai_i,
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic signed [ACC_WIDTH-1:0] bias_i,
    output logic signed [OUT_WIDTH-1:0] out_o,
    output logic signed [ACC_WIDTH-1:0] long_out_o,
    output logic                        sat_o,
    output logic                        sat_d_o
);

    localparam int D_W = ACC_WIDTH + D_W_GROW;
    localparam int P_W = D_W + P_W_GROW;

    localparam logic signed [D_W-1:0] Z_EXT     = D_W'(Z_WEIGHTS);
    localparam logic signed [P_W-1:0] M_EXT     = P_W'({1'b0, M_MUL});
    localparam logic signed [P_W-1:0] ROUND     = P_W'(1) <<< (SHIFT - 1);
    localparam logic signed [P_W-1:0] Z_OUT_EXT = P_W'(Z_OUT);

    localparam logic signed [CLAMP_W-1:0] ONE_C   = CLAMP_W'(1);
    localparam logic signed [CLAMP_W-1:0] OUT_HI  = (ONE_C <<< (OUT_WIDTH - 1)) - ONE_C;
    localparam logic signed [CLAMP_W-1:0] OUT_MIN = -(ONE_C <<< (OUT_WIDTH - 1));
    localparam logic signed [CLAMP_W-1:0] OUT_LO  = (RELU_EN != 0) ? CLAMP_W'(Z_OUT) : OUT_MIN;
    localparam logic signed [CLAMP_W-1:0] LONG_HI = (ONE_C <<< (ACC_WIDTH - 1)) - ONE_C;
    localparam logic signed [CLAMP_W-1:0] LONG_LO = -(ONE_C <<< (ACC_WIDTH - 1));

    logic signed [D_W-1:0]       d_d, d_q;
    logic signed [P_W-1:0]       p_d, p_q;
    logic signed [ACC_WIDTH-1:0] bias1_q, bias2_q;
    logic signed [P_W-1:0]       r_s3, v_s3;
    logic signed [OUT_WIDTH-1:0] out_d, out_q;
    logic signed [ACC_WIDTH-1:0] long_d, long_q;
    logic                        sat_d, sat_q;

    always_comb begin
        d_d = D_W'(acc_i) - D_W'(ai_i) * Z_EXT;
        p_d = P_W'(d_q) * M_EXT;
        // Arithmetic shift after adding half an LSB gives round-half-toward-+inf.
        r_s3   = (p_q + ROUND) >>> SHIFT;
        v_s3   = r_s3 + P_W'(bias2_q) + Z_OUT_EXT;
        out_d  = OUT_WIDTH'(clamp_val(CLAMP_W'(v_s3), OUT_LO, OUT_HI));
        long_d = ACC_WIDTH'(clamp_val(CLAMP_W'(v_s3), LONG_LO, LONG_HI));
        sat_d  = clamp_hit(CLAMP_W'(v_s3), OUT_LO, OUT_HI);
    end

    // NOTE: non-blocking assignments so every stage samples the pre-edge value
    // of the stage before it; blocking here would collapse the pipeline.
    // NOTE: the S1/S2 datapath registers carry no reset -- validity is tracked
    // by the top's valid bits, so their stale contents are never observed.
    always_ff @(posedge clk) begin
        if (en_i) begin
            d_q     <= d_d;
            bias1_q <= bias_i;
            p_q     <= p_d;
            bias2_q <= bias1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            long_q <= '0;
            sat_q  <= 1'b0;
        end else if (out_ld_i) begin
            out_q  <= out_d;
            long_q <= long_d;
            sat_q  <= sat_d;
        end
    end

    assign out_o      = out_q;
    assign long_out_o = long_q;
    assign sat_o      = sat_q;
    assign sat_d_o    = sat_d;

endmodule

// File: rtl/requant_stage.sv
// -----------------------------------------------------------------------------
// requant_stage
// CHANNELS-lane requantisation pipeline, 3-cycle latency, 1 beat/cycle, with
// valid/ready handshake on both sides and a saturation event counter.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake; in_ready = !out_valid || out_ready
//   ai                   shared activation-sum term
//   acc, bias            per-lane accumulators / biases, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   out_valid/out_ready  output handshake
//   out                  per-lane saturated quantised outputs
//   long_out             per-lane results clamped to ACC_WIDTH
//   sat_flags            per-lane output clamp indication for the held beat
//   sat_count            saturating count of beats with any lane clamped
//   sat_clr              synchronous clear of sat_count (wins over increment)
// -----------------------------------------------------------------------------
module requant_stage
    import requant_pkg::*;
#(
    parameter int          CHANNELS  = 4,
    parameter int          ACC_WIDTH = 32,
    parameter int          OUT_WIDTH = 8,
    parameter int          Z_WEIGHTS = 5,
    parameter logic [31:0] M_MUL     = 32'd2094967296,
    parameter int          SHIFT     = 32,
    parameter int          Z_OUT     = 0,
    parameter int          RELU_EN   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ACC_WIDTH-1:0]          ai,
    input  logic [CHANNELS*ACC_WIDTH-1:0] acc,
    input  logic [CHANNELS*ACC_WIDTH-1:0] bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0] out,
    output logic [CHANNELS*ACC_WIDTH-1:0] long_out,
    output logic [CHANNELS-1:0]           sat_flags,
    output logic [SAT_CNT_W-1:0]          sat_count,
    input  logic                          sat_clr
);

    logic                 en, accept, out_ld;
    logic                 v1_d, v1_q, v2_d, v2_q, ov_d, ov_q;
    logic [CHANNELS-1:0]  sat_nxt;
    logic [SAT_CNT_W-1:0] sat_count_d, sat_count_q;

    // NOTE: every always_comb output gets its hold value first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        en     = !ov_q || out_ready;
        accept = in_valid && en;
        out_ld = en && v2_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        ov_d   = ov_q;
        if (en) begin
            // Bubbles shift with the beats so nothing is duplicated or dropped.
            v1_d = accept;
            v2_d = v1_q;
            ov_d = v2_q;
        end
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (out_ld && (|sat_nxt) && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            ov_q        <= 1'b0;
            sat_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            ov_q        <= ov_d;
            sat_count_q <= sat_count_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        requant_lane #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .Z_WEIGHTS (Z_WEIGHTS),
            .M_MUL     (M_MUL),
            .SHIFT     (SHIFT),
            .Z_OUT     (Z_OUT),
            .RELU_EN   (RELU_EN)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en),
            .out_ld_i   (out_ld),
            .ai_i       (ai),
            .acc_i      (acc[i*ACC_WIDTH +: ACC_WIDTH]),
            .bias_i     (bias[i*ACC_WIDTH +: ACC_WIDTH]),
            .out_o      (out[i*OUT_WIDTH +: OUT_WIDTH]),
            .long_out_o (long_out[i*ACC_WIDTH +: ACC_WIDTH]),
            .sat_o      (sat_flags[i]),
            .sat_d_o    (sat_nxt[i])
        );
    end

    assign in_ready  = en;
    assign out_valid = ov_q;
    assign sat_count = sat_count_q;

endmodule

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 Parameter CHANNELS, default 4: number of parallel output lanes.
REQ-002 Parameter ACC_WIDTH, default 32: signed width of acc, ai, bias and long_out per lane.
REQ-003 Parameter OUT_WIDTH, default 8: signed width of each quantised output.
REQ-004 Parameter Z_WEIGHTS, default 5: weight zero-point, signed integer.
REQ-005 Parameter M_MUL, default 2094967296: fixed-point multiplier, unsigned 32-bit, 1..2^32-1.
REQ-006 Parameter SHIFT, default 32: right-shift after multiply, 1..62.
REQ-007 Parameter Z_OUT, default 0: output zero-point added before saturation.
REQ-008 Parameter RELU_EN, default 0: 1 clamps the lower bound to Z_OUT.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 in_valid  in  1  input beat valid.
REQ-012 in_ready  out  1  block accepts a beat this cycle.
REQ-013 ai  in  ACC_WIDTH  signed activation-sum term, shared by all lanes.
REQ-014 acc  in  CHANNELS*ACC_WIDTH  signed accumulators, lane i at bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-015 bias  in  CHANNELS*ACC_WIDTH  signed per-lane bias in output scale.
REQ-016 out_valid  out  1  output beat valid.
REQ-017 out_ready  in  1  downstream accepts.
REQ-018 out  out  CHANNELS*OUT_WIDTH  saturated quantised outputs.
REQ-019 long_out  out  CHANNELS*ACC_WIDTH  pre-narrowing result, saturated to ACC_WIDTH.
REQ-020 sat_flags  out  CHANNELS  per-lane: out saturated in current beat.
REQ-021 sat_count  out  16  saturating count of beats with any sat_flags bit set.
REQ-022 sat_clr  in  1  synchronous clear of sat_count.

Function
REQ-023 All arithmetic signed, full precision until final narrowing; no intermediate truncation.
REQ-024 Stage 1: d = acc - Z_WEIGHTS*ai, width ACC_WIDTH+33.
REQ-025 Stage 2: p = d * M_MUL, M_MUL zero-extended (non-negative).
REQ-026 Stage 3: r = (p + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf); v = r + bias + Z_OUT.
REQ-027 Narrowing: out = clamp(v, lo, 2^(OUT_WIDTH-1)-1), lo = Z_OUT if RELU_EN else -2^(OUT_WIDTH-1); sat_flags[i]=1 iff clamp active on lane i.
REQ-028 long_out = v clamped to signed ACC_WIDTH range.
REQ-029 Latency exactly 3 cycles from accepted beat to out_valid when out_ready held high; throughput 1 beat/cycle.
REQ-030 Pipeline advance enable en = !out_valid || out_ready; in_ready = en; beat accepted iff in_valid && in_ready.
REQ-031 When en=0 all stage registers, out, long_out, sat_flags hold; out_valid, once high, holds until out_ready.
REQ-032 Bubbles advance with en; stage valid bits shift so no beat is duplicated or dropped.
REQ-033 sat_count increments by 1 on each output-register load with any sat_flags bit set, stops at 0xFFFF.
REQ-034 sat_clr has priority over a simultaneous increment: count becomes 0.

Reset
REQ-035 On rst: all stage valid bits, out_valid, out, long_out, sat_flags, sat_count = 0; in_ready = 1 in the cycle after rst deasserts.
REQ-036 rst mid-operation discards all in-flight beats; no out_valid for them afterwards.

Structure
REQ-037 Package requant_pkg holds lane-width localparams (D_W, P_W), the saturation helper function, and the sat_count width constant.
REQ-038 Sub-module requant_lane implements one lane's 3-stage datapath with en input; top instantiates CHANNELS copies and owns handshake, valid pipeline and sat_count.

Verification (CHANNELS=4, OUT_WIDTH=8, Z_WEIGHTS=5, M_MUL=2^31, SHIFT=32, Z_OUT=0 unless stated)
REQ-039 acc=100, ai=10, bias=3, out_ready=1 -> out=28, long_out=28, out_valid exactly 3 cycles after accept.
REQ-040 Rounding: acc=5, ai=0, bias=0 -> out=3; acc=-5 -> out=-2.
REQ-041 Saturation: acc=1000, ai=0 -> out=127, long_out=500, sat_flags[i]=1, sat_count=1; acc=-1000 -> out=-128; RELU_EN=1, acc=-100 -> out=0, sat flag set.
REQ-042 Back-pressure: 6 back-to-back beats, out_ready low for cycles 4-7 -> in_ready low while out_valid && !out_ready; all 6 beats out in order, none lost or repeated.
REQ-043 rst asserted with 2 beats in flight -> out_valid=0 after reset, those beats never emitted; sat_clr concurrent with saturating beat -> sat_count=0.
